encryption_core: RTL and testbench
==================================

ENCRYPTION_CORE -- requirements
Module: encryption_core

Interface
REQ-001 Port clk, input, 1, sole clock; all state SHALL change on its rising edge only.
REQ-002 Port rst_n, input, 1, asynchronous active-low reset.
REQ-003 Port key, input, 256, round keys: round1 key[63:0], round2 key[127:64], round3 key[191:128], round4 key[255:192]; held stable while busy.
REQ-004 Port load, input, 1, pulse that loads the internal state from rs*_init and lfsr_init.
REQ-005 Ports rs1_init..rs4_init and lfsr_init, input, 16 each, initial state values.
REQ-006 Port in_valid, input, 1, plaintext word valid.
REQ-007 Port in_ready, output, 1, core accepts a word.
REQ-008 Port pt, input, 16, plaintext word.
REQ-009 Port out_valid, output, 1, ciphertext valid.
REQ-010 Port out_ready, input, 1, consumer accepts the ciphertext.
REQ-011 Port ct, output, 16, ciphertext word.
REQ-012 Ports rs1..rs4 and lfsr, output, 16 each, current state registers, so a paired decryption block can be fed.

Function
REQ-013 The core SHALL implement an FSM with states IDLE, ROUND and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE, and 0 in IDLE while load=1.
REQ-015 Load rule: in IDLE with load=1, the core SHALL register rs1..rs4 and lfsr from their init ports and stay in IDLE; load outside IDLE SHALL be ignored.
REQ-016 Accept rule: in IDLE with in_valid=1 and load=0, the core SHALL latch pt, go to ROUND and set round counter cnt=0.
REQ-017 The core SHALL contain one encryption_function instance (16-bit in, 64-bit key, 16-bit out, combinational) that is time-shared across rounds.
REQ-018 ROUND, one round per cycle; all additions mod 2^16 with carry discarded:
  - cnt0: v12 <= Ek1(pt + rs1)
  - cnt1: v23 <= Ek2(v12 + rs2)
  - cnt2: v34 <= Ek3(v23 + rs3)
  - cnt3: ct <= Ek4(v34 + rs4)
REQ-019 On the cnt3 edge, the core SHALL also update the state using the pre-update values, then go to DONE:
  - rs1' = rs1 + v34
  - rs3' = rs3 + v23
  - lfsr' = {lfsr[14:0], lfsr[15]^lfsr[14]^lfsr[11]^lfsr[9]^lfsr[6]^lfsr[2]}
  - rs2' = rs2 + v12 + rs1'
  - rs4' = rs4 + v12 + rs3' + lfsr'
REQ-020 Latency: out_valid SHALL rise exactly 4 clock edges after the accept edge.
REQ-021 In DONE, out_valid=1 and ct SHALL hold stable until out_ready=1.
REQ-022 On the edge with out_ready=1 in DONE, the core SHALL return to IDLE with out_valid=0; the next word is accepted at the earliest one cycle later, giving a minimum of 6 cycles per word.
REQ-023 in_valid, pt and load changes during ROUND or DONE SHALL have no effect.
REQ-024 ct and the state outputs SHALL be registered, with no combinational path from any input.

Reset
REQ-025 When rst_n=0, the core SHALL immediately go to IDLE and clear cnt, v12, v23, v34, ct, rs1..rs4, lfsr and out_valid to 0; in_ready SHALL then be 1.
REQ-026 A reset mid-ROUND or mid-DONE SHALL abort the word without updating state and without emitting ct.
REQ-027 The core SHALL leave reset synchronously to clk, and the first accept SHALL be possible on the first edge with rst_n=1.

Verification
REQ-028 Reset, load rs1..4=0x0001,0x0002,0x0003,0x0004 and lfsr=0x1234, then stay idle -> outputs read back 0x0001..0x0004 and 0x1234, in_ready=1, out_valid=0.
REQ-029 Accept pt=0xA5A5 -> out_valid high exactly 4 edges later; ct and rs1..rs4/lfsr match a bit-accurate model of REQ-018/019; lfsr'=0x2468 (feedback 0).
REQ-030 Wrap-around: load rs1..rs4=0xFFFF and lfsr=0x8000, then encrypt pt=0x0001 -> first adder input 0x0000; carries dropped; lfsr'=0x0001 (feedback 1); matches model.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and pt toggling -> ct stable, in_ready=0, no second word accepted; out_ready=1 -> IDLE next edge.
REQ-032 Round trip: feed 8 consecutive words into encryption_core and each pre-update state plus ct into the existing decryption block -> original pt recovered every word.
REQ-033 Assert rst_n=0 at cnt2 -> all outputs 0 immediately; after release, the state reads 0 and no out_valid pulse appears.

Source files
------------

// File: rtl/encryption_core.sv
// Four-round block core for 16-bit words. One round function is shared over four cycles.
// Each finished word also updates the running state (rs1..rs4, lfsr).

module encryption_function (
  input  logic [15:0] din,
  input  logic [63:0] key,
  output logic [15:0] dout
);
  logic [15:0] a, b, c;

  // Each step is invertible: xor, rotate+add, rotate+xor, add.
  always_comb begin
    a    = din ^ key[15:0];
    b    = {a[12:0], a[15:13]} + key[31:16];
    c    = {b[10:0], b[15:11]} ^ key[47:32];
    dout = c + key[63:48];
  end
endmodule

module encryption_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key,
  input  logic         load,
  input  logic [15:0]  rs1_init,
  input  logic [15:0]  rs2_init,
  input  logic [15:0]  rs3_init,
  input  logic [15:0]  rs4_init,
  input  logic [15:0]  lfsr_init,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  pt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  ct,
  output logic [15:0]  rs1,
  output logic [15:0]  rs2,
  output logic [15:0]  rs3,
  output logic [15:0]  rs4,
  output logic [15:0]  lfsr
);
  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] pt_q, pt_d, v12_q, v12_d, v23_q, v23_d, v34_q, v34_d, ct_q, ct_d;
  logic [15:0] rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d, rs4_q, rs4_d, lfsr_q, lfsr_d;
  logic [15:0] ef_in, ef_out;
  logic [63:0] ef_key;
  logic        lfsr_fb;

  encryption_function u_ef (
    .din  (ef_in),
    .key  (ef_key),
    .dout (ef_out)
  );

  always_comb begin
    unique case (cnt_q)
      2'd0:    begin ef_in = pt_q  + rs1_q; ef_key = key[63:0];    end
      2'd1:    begin ef_in = v12_q + rs2_q; ef_key = key[127:64];  end
      2'd2:    begin ef_in = v23_q + rs3_q; ef_key = key[191:128]; end
      default: begin ef_in = v34_q + rs4_q; ef_key = key[255:192]; end
    endcase
  end

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[11] ^ lfsr_q[9] ^ lfsr_q[6] ^ lfsr_q[2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    v12_d   = v12_q;
    v23_d   = v23_q;
    v34_d   = v34_q;
    ct_d    = ct_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rs3_d   = rs3_q;
    rs4_d   = rs4_q;
    lfsr_d  = lfsr_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          rs1_d  = rs1_init;
          rs2_d  = rs2_init;
          rs3_d  = rs3_init;
          rs4_d  = rs4_init;
          lfsr_d = lfsr_init;
        end else if (in_valid) begin
          pt_d    = pt;
          cnt_d   = 2'd0;
          state_d = StRound;
        end
      end
      StRound: begin
        cnt_d = cnt_q + 2'd1;
        unique case (cnt_q)
          2'd0: v12_d = ef_out;
          2'd1: v23_d = ef_out;
          2'd2: v34_d = ef_out;
          default: begin
            ct_d    = ef_out;
            // rs2/rs4 chain on the freshly updated rs1/rs3/lfsr values.
            rs1_d   = rs1_q + v34_q;
            rs3_d   = rs3_q + v23_q;
            lfsr_d  = {lfsr_q[14:0], lfsr_fb};
            rs2_d   = rs2_q + v12_q + rs1_d;
            rs4_d   = rs4_q + v12_q + rs3_d + lfsr_d;
            state_d = StDone;
          end
        endcase
      end
      default: begin
        if (out_ready) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      pt_q    <= 16'h0;
      v12_q   <= 16'h0;
      v23_q   <= 16'h0;
      v34_q   <= 16'h0;
      ct_q    <= 16'h0;
      rs1_q   <= 16'h0;
      rs2_q   <= 16'h0;
      rs3_q   <= 16'h0;
      rs4_q   <= 16'h0;
      lfsr_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pt_q    <= pt_d;
      v12_q   <= v12_d;
      v23_q   <= v23_d;
      v34_q   <= v34_d;
      ct_q    <= ct_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rs3_q   <= rs3_d;
      rs4_q   <= rs4_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !load;
  assign out_valid = (state_q == StDone);
  assign ct        = ct_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rs3       = rs3_q;
  assign rs4       = rs4_q;
  assign lfsr      = lfsr_q;
endmodule

// File: tb/tb_encryption_core.sv
// Randomized bench for encryption_core against a word-level reference model,
// including an inverse cipher to check round-trip recovery of plaintext.

module tb_encryption_core;
  logic         clk, rst_n, load, in_valid, in_ready, out_valid, out_ready;
  logic [255:0] key;
  logic [15:0]  rs1_init, rs2_init, rs3_init, rs4_init, lfsr_init, pt, ct;
  logic [15:0]  rs1, rs2, rs3, rs4, lfsr;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state.
  logic [15:0] m_rs1, m_rs2, m_rs3, m_rs4, m_lfsr, m_ct;

  encryption_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .load      (load),
    .rs1_init  (rs1_init),
    .rs2_init  (rs2_init),
    .rs3_init  (rs3_init),
    .rs4_init  (rs4_init),
    .lfsr_init (lfsr_init),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt        (pt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ct        (ct),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs3       (rs3),
    .rs4       (rs4),
    .lfsr      (lfsr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
    return (x << n) | (x >> (16 - n));
  endfunction

  function automatic logic [15:0] ek(input logic [15:0] x, input logic [63:0] k);
    logic [15:0] t;
    t = x ^ k[15:0];
    t = rotl(t, 3) + k[31:16];
    t = rotl(t, 5) ^ k[47:32];
    return t + k[63:48];
  endfunction

  function automatic logic [15:0] ek_inv(input logic [15:0] y, input logic [63:0] k);
    logic [15:0] t;
    t = y - k[63:48];
    t = rotl(t ^ k[47:32], 11);
    t = rotl(t - k[31:16], 13);
    return t ^ k[15:0];
  endfunction

  function automatic logic [63:0] rk(input int r);
    return key[64*r +: 64];
  endfunction

  // Encrypt one word on the model and advance the model state.
  task automatic model_word(input logic [15:0] p);
    logic [15:0] v12, v23, v34, fb;
    v12   = ek(p + m_rs1, rk(0));
    v23   = ek(v12 + m_rs2, rk(1));
    v34   = ek(v23 + m_rs3, rk(2));
    m_ct  = ek(v34 + m_rs4, rk(3));
    m_rs1 = m_rs1 + v34;
    m_rs3 = m_rs3 + v23;
    fb    = {15'd0, ^{m_lfsr[15], m_lfsr[14], m_lfsr[11], m_lfsr[9], m_lfsr[6], m_lfsr[2]}};
    m_lfsr = (m_lfsr << 1) | fb;
    m_rs2 = m_rs2 + v12 + m_rs1;
    m_rs4 = m_rs4 + v12 + m_rs3 + m_lfsr;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".rs1"}, {16'd0, rs1}, {16'd0, m_rs1});
    check_eq({tag, ".rs2"}, {16'd0, rs2}, {16'd0, m_rs2});
    check_eq({tag, ".rs3"}, {16'd0, rs3}, {16'd0, m_rs3});
    check_eq({tag, ".rs4"}, {16'd0, rs4}, {16'd0, m_rs4});
    check_eq({tag, ".lfsr"}, {16'd0, lfsr}, {16'd0, m_lfsr});
  endtask

  task automatic do_load(input logic [15:0] a, b, c, d, l);
    @(negedge clk);
    load = 1'b1;
    rs1_init = a; rs2_init = b; rs3_init = c; rs4_init = d; lfsr_init = l;
    #1 check_eq("load_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    load = 1'b0;
    m_rs1 = a; m_rs2 = b; m_rs3 = c; m_rs4 = d; m_lfsr = l;
    #1 check_state("load");
    check_eq("load_in_ready_after", {31'd0, in_ready}, 32'd1);
    check_eq("load_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  // Encrypt one word; hold out_ready low for 'hold' cycles while poking inputs.
  task automatic do_word(input logic [15:0] p, input int hold);
    logic [15:0] p1, p2, p3, p4, v;
    int edges;
    @(negedge clk);
    p1 = rs1; p2 = rs2; p3 = rs3; p4 = rs4;
    in_valid = 1'b1;
    pt = p;
    #1 check_eq("accept_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    pt = ~p;
    model_word(p);
    edges = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 edges++;
      if (out_valid) break;
    end
    check_eq("latency", edges, 4);
    check_eq("ct", {16'd0, ct}, {16'd0, m_ct});
    check_state("word");
    // Round trip through the inverse using the pre-update state.
    v = ek_inv(ct, rk(3)) - p4;
    v = ek_inv(v, rk(2)) - p3;
    v = ek_inv(v, rk(1)) - p2;
    v = ek_inv(v, rk(0)) - p1;
    check_eq("roundtrip", {16'd0, v}, {16'd0, p});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      pt = 16'($urandom);
      load = 1'b1;
      rs1_init = 16'($urandom);
      #1 check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_ct", {16'd0, ct}, {16'd0, m_ct});
      check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    load = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 check_eq("done_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("done_in_ready", {31'd0, in_ready}, 32'd1);
    if (hold > 0) check_state("bp_state");
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pt = 16'h0;
    rs1_init = 16'h0; rs2_init = 16'h0; rs3_init = 16'h0; rs4_init = 16'h0; lfsr_init = 16'h0;
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    m_rs1 = 16'h0; m_rs2 = 16'h0; m_rs3 = 16'h0; m_rs4 = 16'h0; m_lfsr = 16'h0; m_ct = 16'h0;
    #2;
    check_eq("rst_ct", {16'd0, ct}, 32'd0);
    check_state("rst");
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    do_load(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h1234);
    do_word(16'hA5A5, 0);
    check_eq("lfsr_fb0", {16'd0, lfsr}, 32'h2468);

    do_load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000);
    do_word(16'h0001, 0);
    check_eq("lfsr_fb1", {16'd0, lfsr}, 32'h0001);

    do_word(16'($urandom), 10);

    for (int w = 0; w < 8; w++) begin
      if (w == 3) do_load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                          16'($urandom));
      do_word(16'($urandom), int'($urandom_range(0, 2)));
    end

    // Reset while the word sits at cnt2.
    @(negedge clk);
    in_valid = 1'b1;
    pt = 16'($urandom);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    m_rs1 = 16'h0; m_rs2 = 16'h0; m_rs3 = 16'h0; m_rs4 = 16'h0; m_lfsr = 16'h0;
    check_eq("midrst_ct", {16'd0, ct}, 32'd0);
    check_state("midrst");
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    end
    check_state("post_rst");
    do_word(16'($urandom), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
